// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side adapter for a standard-mode (non-FWFT) block-RAM FIFO with a fixed
// read latency. Reads are issued against a credit count so every word fetched
// has a guaranteed slot in a 4-entry skid buffer. The buffered words are then
// presented as a valid/ready stream. Words are never dropped, duplicated or
// reordered, and the FIFO is never read while it reports empty.
//
// Parameters
//   WIDTH       data width, must match the FIFO data width
//   RD_LATENCY  cycles from fifo_rd_en to valid fifo_dout (1 or 2)
//
// Ports
//   clk         FIFO read clock
//   rst         synchronous, active-high reset
//   fifo_rd_en  read strobe to the FIFO (combinational, depends on m_ready)
//   fifo_dout   FIFO read data
//   fifo_empty  FIFO empty flag
//   fifo_rderr  FIFO read-error flag (used only with the error-check option)
//   m_valid     stream word available (registered)
//   m_ready     consumer accepts the word
//   m_data      stream word (registered)
//   err         sticky read-error flag (constant 0 without the option)
//
// Build option
//   FIFO_STREAM_READER_ERRCHK_EN  enables the sticky err flag driven by
//   fifo_rderr and a simulation check that the FIFO is never read while empty.
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int WIDTH      = 36,
  parameter int RD_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  input  logic             fifo_rderr,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             err
);

  localparam int DEPTH = 4;

  logic [WIDTH-1:0]      skid_mem [DEPTH];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            occ;
  logic [RD_LATENCY-1:0] tracker;   // one bit per read still in the FIFO pipeline
  logic [2:0]            inflight;
  logic [2:0]            credit_need;
  logic                  land;
  logic                  pop;

  // The oldest tracker stage marks the cycle in which fifo_dout is valid.
  assign land = tracker[RD_LATENCY-1];
  assign pop  = m_valid & m_ready;

  // NOTE: give every always_comb output a default before any conditional
  // logic; a path that leaves it unassigned infers a latch.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {2'b00, tracker[i]};
    end
  end

  // Slots already claimed (buffered plus in flight) minus the slot being freed
  // this cycle. occ + inflight never exceeds 4 and pop implies occ >= 1, so
  // the 3-bit result neither overflows nor underflows.
  assign credit_need = occ + inflight - {2'b00, pop};
  assign fifo_rd_en  = !rst && !fifo_empty && (credit_need < 3'd4);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      tracker <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      // NOTE: the skid storage is reset on purpose: m_data is read straight
      // from it and must be 0 out of reset. Larger memories are normally left
      // unreset.
      for (int i = 0; i < DEPTH; i++) begin
        skid_mem[i] <= '0;
      end
    end else begin
      tracker[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tracker[i] <= tracker[i-1];
      end

      if (land) begin
        skid_mem[wr_ptr] <= fifo_dout;
        wr_ptr           <= wr_ptr + 2'd1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end

      occ <= occ + {2'b00, land} - {2'b00, pop};
    end
  end

  assign m_valid = (occ != 3'd0);
  assign m_data  = skid_mem[rd_ptr];

`ifdef FIFO_STREAM_READER_ERRCHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (fifo_rderr) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_rd_en && fifo_empty))
        else $error("fifo_stream_reader: read issued while FIFO empty");
    end
  end
`endif
`else
  // Error checking is compiled out: the flag is constant and the FIFO error
  // input is deliberately left unconnected.
  logic unused_rderr;
  assign unused_rderr = fifo_rderr;
  assign err          = 1'b0;
`endif

`ifndef SYNTHESIS
  // A landing word must always find a free slot in the skid buffer.
  always @(posedge clk) begin
    if (!rst) begin
      assert ({1'b0, occ} + {1'b0, inflight} <= 4'd4)
        else $error("fifo_stream_reader: occ + inflight exceeds buffer depth");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Two instances run side by side from the same stimulus: lane 0 with
// RD_LATENCY=1, lane 1 with RD_LATENCY=2. Each lane has its own behavioural
// FIFO (a queue plus a read-latency delay line) and its own expected-word
// queue. Stimulus pushes words into both; a negedge monitor pops and compares
// whenever a lane completes a stream beat.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int WIDTH = 36;
  localparam int NL    = 2;

  typedef logic [WIDTH-1:0] word_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  m_ready = 1'b0;
  logic  fifo_rderr = 1'b0;

  logic  rd_en [NL];
  word_t dout  [NL] = '{default: '0};
  logic  empty [NL] = '{default: 1'b1};
  logic  mv    [NL];
  word_t md    [NL];
  logic  err_o [NL];

  fifo_stream_reader #(.WIDTH(WIDTH), .RD_LATENCY(1)) dut_l1 (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd_en (rd_en[0]),
    .fifo_dout  (dout[0]),
    .fifo_empty (empty[0]),
    .fifo_rderr (fifo_rderr),
    .m_valid    (mv[0]),
    .m_ready    (m_ready),
    .m_data     (md[0]),
    .err        (err_o[0])
  );

  fifo_stream_reader #(.WIDTH(WIDTH), .RD_LATENCY(2)) dut_l2 (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd_en (rd_en[1]),
    .fifo_dout  (dout[1]),
    .fifo_empty (empty[1]),
    .fifo_rderr (fifo_rderr),
    .m_valid    (mv[1]),
    .m_ready    (m_ready),
    .m_data     (md[1]),
    .err        (err_o[1])
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  word_t fq    [NL][$];              // FIFO contents
  word_t exp_q [NL][$];              // words still owed on the stream
  word_t pipe_d [NL][2];             // FIFO read-latency delay line
  logic  pipe_v [NL][2] = '{default: 1'b0};

  int    rd_cnt    [NL] = '{default: 0};  // reads since reset
  int    pop_cnt   [NL] = '{default: 0};  // beats since reset
  int    rd_pulses [NL] = '{default: 0};
  int    beats     [NL] = '{default: 0};
  int    first_rd  [NL] = '{default: -1};
  int    first_vld [NL] = '{default: -1};
  int    gaps      [NL] = '{default: 0};
  logic  stall_q   [NL] = '{default: 1'b0};
  word_t stall_d   [NL];
  logic  rst_q = 1'b1;

  function automatic int lat(int k);
    return k + 1;
  endfunction

  task automatic check(string name, int k, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s lane%0d (lat %0d) cycle %0d: got %0h expected %0h",
               name, k, lat(k), cyc, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor + FIFO model, evaluated mid-cycle
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < NL; k++) begin
      if (rst) begin
        check("rd_en_in_reset", k, rd_en[k], 1'b0);
        rd_cnt[k]  = 0;
        pop_cnt[k] = 0;
        stall_q[k] = 1'b0;
      end else begin
        if (rst_q) check("valid_after_reset", k, mv[k], 1'b0);
        check("rd_while_empty", k, rd_en[k] & empty[k], 1'b0);
        // Outstanding reads (buffered or in flight) may never exceed 4.
        check("credit_bound", k, (rd_cnt[k] - pop_cnt[k]) > 4, 1'b0);

        if (stall_q[k]) begin
          check("hold_valid", k, mv[k], 1'b1);
          check("hold_data",  k, md[k], stall_d[k]);
        end

        if (mv[k] && first_vld[k] < 0) first_vld[k] = cyc;
        if (!mv[k] && first_vld[k] >= 0 && exp_q[k].size() != 0) gaps[k]++;

        if (mv[k] && m_ready) begin
          beats[k]++;
          pop_cnt[k]++;
          if (exp_q[k].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_beat lane%0d cycle %0d: got %0h expected no beat",
                     k, cyc, md[k]);
          end else begin
            check("data", k, md[k], exp_q[k].pop_front());
          end
        end

        stall_q[k] = mv[k] && !m_ready;
        stall_d[k] = md[k];

        if (rd_en[k]) begin
          rd_cnt[k]++;
          rd_pulses[k]++;
          if (first_rd[k] < 0) first_rd[k] = cyc;
        end
      end

      // FIFO read pipeline: a read in this cycle delivers its word lat(k)
      // cycles later.
      pipe_v[k][1] = pipe_v[k][0];
      pipe_d[k][1] = pipe_d[k][0];
      pipe_v[k][0] = !rst && rd_en[k] && (fq[k].size() != 0);
      pipe_d[k][0] = pipe_v[k][0] ? fq[k].pop_front() : '0;
    end
    rst_q = rst;
  end

  // FIFO output drive, just after each active edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NL; k++) begin
      empty[k] = (fq[k].size() == 0);
      if (pipe_v[k][lat(k)-1]) dout[k] = pipe_d[k][lat(k)-1];
      else                     dout[k] = word_t'({$urandom(), $urandom()});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(word_t w);
    for (int k = 0; k < NL; k++) begin
      fq[k].push_back(w);
      exp_q[k].push_back(w);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NL; k++) begin
      rd_pulses[k] = 0;
      beats[k]     = 0;
      first_rd[k]  = -1;
      first_vld[k] = -1;
      gaps[k]      = 0;
    end
  endtask

  task automatic drain(int budget);
    m_ready = 1'b1;
    for (int i = 0; i < budget && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) begin
      step();
    end
    for (int k = 0; k < NL; k++) check("drain_done", k, exp_q[k].size(), 0);
  endtask

  logic exp_err;
  int   pushed;

  initial begin
    // Reset state
    repeat (3) step();
    for (int k = 0; k < NL; k++) begin
      check("reset_rd_en", k, rd_en[k], 1'b0);
      check("reset_valid", k, mv[k],    1'b0);
      check("reset_data",  k, md[k],    '0);
      check("reset_err",   k, err_o[k], 1'b0);
    end
    rst = 1'b0;
    step();

    // Basic flow: 16 words, consumer always ready
    clear_counts();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(word_t'(i));
    drain(200);
    repeat (3) step();
    for (int k = 0; k < NL; k++) begin
      check("first_valid_latency", k, first_vld[k] - first_rd[k], lat(k) + 1);
      check("flow_gaps",  k, gaps[k],  0);
      check("flow_beats", k, beats[k], 16);
    end

    // Backpressure: 10 words, consumer stalled for 20 cycles
    clear_counts();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(word_t'(36'h100 + i));
    repeat (20) step();
    for (int k = 0; k < NL; k++) begin
      check("bp_rd_pulses", k, rd_pulses[k], 4);
      check("bp_valid",     k, mv[k], 1'b1);
      check("bp_data",      k, md[k], 36'h100);
    end
    drain(200);
    for (int k = 0; k < NL; k++) check("bp_beats", k, beats[k], 10);

    // Single word into an empty FIFO
    repeat (5) step();
    clear_counts();
    m_ready = 1'b1;
    push(36'hABC);
    repeat (12) step();
    for (int k = 0; k < NL; k++) begin
      check("single_rd_pulses", k, rd_pulses[k], 1);
      check("single_beats",     k, beats[k],     1);
    end

    // Random consumer over 1000 words, bursty producer
    clear_counts();
    pushed = 0;
    for (int c = 0; c < 20000 && (pushed < 1000 || exp_q[0].size() != 0 || exp_q[1].size() != 0); c++) begin
      if (pushed < 1000 && $urandom_range(3) < ((pushed / 100) % 2 == 0 ? 1 : 3)) begin
        push(word_t'({$urandom(), $urandom()}));
        pushed++;
      end
      m_ready = ($urandom_range(1) == 1);
      step();
    end
    for (int k = 0; k < NL; k++) begin
      check("random_beats", k, beats[k], 1000);
      check("random_left",  k, exp_q[k].size(), 0);
    end

    // Reset mid-stream with reads in flight and words buffered
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(word_t'(36'h200 + i));
    repeat (3) step();
    m_ready = 1'b1;
    rst     = 1'b1;
    for (int k = 0; k < NL; k++) begin
      fq[k].delete();
      exp_q[k].delete();
    end
    step();
    rst = 1'b0;
    repeat (5) step();
    for (int k = 0; k < NL; k++) check("post_reset_idle", k, mv[k], 1'b0);
    clear_counts();
    for (int i = 0; i < 5; i++) push(word_t'(36'h300 + i));
    drain(200);
    for (int k = 0; k < NL; k++) check("post_reset_beats", k, beats[k], 5);

    // Read-error flag
`ifdef FIFO_STREAM_READER_ERRCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    fifo_rderr = 1'b1;
    step();
    fifo_rderr = 1'b0;
    for (int k = 0; k < NL; k++) check("err_set", k, err_o[k], exp_err);
    repeat (3) step();
    for (int k = 0; k < NL; k++) check("err_sticky", k, err_o[k], exp_err);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < NL; k++) check("err_cleared", k, err_o[k], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
